// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, XOR parity, one stop bit.
// The line is oversampled on an external tick. Start-bit glitches are rejected.
module uart_rx #(
    parameter int OS_RATE     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       RX_os_tick,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(OS_RATE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OS_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OS_RATE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     w_rx_s;
    logic [CNT_W-1:0]         r_cnt;
    logic [CNT_W-1:0]         w_cnt_nxt;
    logic [2:0]               r_bit_idx;
    logic [2:0]               w_bit_idx_nxt;
    logic [7:0]               r_shift;
    logic [7:0]               w_shift_nxt;
    logic                     r_par;
    logic                     w_par_nxt;
    logic                     w_done;
    logic [7:0]               r_data_out;
    logic                     r_valid;
    logic                     r_par_err;
    logic                     r_frm_err;
    logic                     r_busy;

    // Synchroniser resets to the idle (high) line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_par_nxt     = r_par;
        w_done        = 1'b0;
        if (RX_os_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                        w_cnt_nxt   = '0;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_MID) begin
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = 3'd0;
                        w_state_nxt   = w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_MAX) begin
                        w_shift_nxt   = {w_rx_s, r_shift[7:1]};
                        w_cnt_nxt     = '0;
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            w_state_nxt = S_PARITY;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (r_cnt == CNT_MAX) begin
                        w_par_nxt   = w_rx_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_MAX) begin
                        w_done      = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_par      <= 1'b0;
            r_data_out <= 8'd0;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_par     <= w_par_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_valid   <= w_done;
            // Errored frames still strobe valid so the host sees every completed frame.
            if (w_done) begin
                r_data_out <= r_shift;
                r_par_err  <= r_par ^ (^r_shift);
                r_frm_err  <= ~w_rx_s;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_valid;
    assign parity_err = r_par_err;
    assign frame_err  = r_frm_err;
    assign busy       = r_busy;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver that pairs with the team's uart_tx. It deserialises the 11-bit frame: start(0), data[0..7] LSB first, parity, stop(1). The parity bit is the XOR of the 8 data bits. The input line is oversampled using a 1-cycle tick pulse from an external baud generator at OS_RATE times the bit rate. The block presents the received byte, a one-cycle valid strobe, and parity/framing error flags to the host logic.

Parameters:
OS_RATE, 16, oversample ticks per bit; even, minimum 8
SYNC_STAGES, 2, flops in the rx input synchroniser; minimum 2

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
RX_os_tick  input  1  1-cycle pulse at OS_RATE x baud
data_out  output  8  last received byte
data_valid  output  1  1-cycle pulse on frame completion
parity_err  output  1  parity mismatch on last frame
frame_err  output  1  stop bit sampled low on last frame
busy  output  1  high while a frame is being received (state != IDLE)

Behaviour:
- Clocking and reset: one clock domain (clk). reset_n is asynchronous and active-low.
- Reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
  - Synchroniser flops=1 (idle). State=IDLE, tick counter=0, bit index=0, shift register=0.
- Input path: rx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Tick gating: the tick counter (log2(OS_RATE) bits) and all sampling advance only on clk edges where RX_os_tick=1. No state change occurs on non-tick cycles, except that data_valid deasserts.
- State IDLE:
  - On a tick with rx_s=0: go to START, counter=0, busy=1.
- State START (start-bit validation):
  - Each tick: counter+1.
  - On the tick where counter==OS_RATE/2-1 (mid-bit), rx_s is sampled:
    - rx_s=0: go to DATA, counter=0, bit index=0.
    - rx_s=1: glitch. Return to IDLE, busy=0, no flags change, no data_valid.
- State DATA:
  - Each tick: counter+1.
  - On the tick where counter==OS_RATE-1: shift rx_s into the MSB of the shift register (right shift, so the first bit received ends up in bit 0). Then counter=0 and bit index+1.
  - After the sample with bit index==7: go to PARITY.
- State PARITY:
  - On the tick where counter==OS_RATE-1: capture rx_s as the parity bit, counter=0, go to STOP.
- State STOP:
  - On the tick where counter==OS_RATE-1, sample rx_s. On the same edge:
    - data_out <= shift register.
    - parity_err <= (parity bit != XOR of the 8 data bits).
    - frame_err <= ~rx_s.
    - data_valid <= 1.
    - State goes to IDLE, busy <= 0.
- data_valid: exactly one clk wide and self-clearing on the next clk. It is asserted for every completed frame, errors included.
- Output hold: data_out and the error flags hold their values until the next completed frame overwrites them.
- Latency: data_valid rises one clk after the tick edge that samples the mid-point of the stop bit, plus SYNC_STAGES clk of input delay relative to the line.
- Back-to-back frames: after STOP the block is in IDLE and can detect the next start edge on the very next tick. No idle bit is required between frames.
- Frame error / break (stop sampled low): the block still returns to IDLE. If rx_s stays low, a new START is entered on the next tick. A held break therefore yields repeated frame_err frames of 0x00.
- Reset mid-frame: asserting reset_n=0 at any point aborts the frame immediately. All state and outputs return to reset values, and no data_valid is produced.
- Counters: the tick counter never exceeds OS_RATE-1 and wraps to 0 only on an explicit reset-to-0 at a sample point. The bit index is 3 bits and is cleared on entry to DATA.

Test Plan:
- Valid frame: OS_RATE=16, tick every clk. Drive 0xA5 LSB first, parity 0, stop 1 -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0, busy low afterwards.
- Parity error: drive 0x3C with parity bit 1 (expected 0) -> data_valid=1, data_out=0x3C, parity_err=1, frame_err=0.
- Framing error: drive 0x81 with correct parity 0 and stop bit 0 -> data_valid=1, data_out=0x81, frame_err=1. Then release the line high -> no further data_valid.
- Start glitch: pulse rx low for 4 ticks, then high -> busy rises then falls at tick 8, no data_valid, flags unchanged from the previous frame.
- Reset mid-frame: reset_n low during data bit 4 of 0xFF -> all outputs 0 on assertion. After release, the next full frame 0x5A is received correctly.
- Loopback and back-to-back: connect uart_tx (TX_baud_tick every 16 ticks) to rx and send 0x00, 0xFF, 0x55 consecutively -> three data_valid pulses with matching data and no error flags.
